// File: rtl/wb_checker.sv
// wb_checker: writeback scoreboard for a pipeline under test.
// Expected values (or skip markers) are queued ahead of time. Each wb_valid
// strobe retires the queue head against WB_Data, and the result goes to
// saturating counters.
//
// Ports
//   clk, reset               clock, synchronous active-high reset
//   exp_valid/exp_ready      handshake for queueing {exp_skip, exp_data}
//   wb_valid, WB_Data        writeback sample under test
//   pass/fail/skip_count     result counters (saturating, CNT_W bits)
//   cycle                    cycles since reset deassertion (saturating)
//   mismatch                 one-cycle pulse after a failing compare
//   first_fail_*             cycle/expected/observed of the first failure
//   underflow                sticky: a sample arrived while the queue was empty
//   done                     queue empty and at least one entry consumed
module wb_checker #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              exp_valid,
    output logic              exp_ready,
    input  logic [DATA_W-1:0] exp_data,
    input  logic              exp_skip,
    input  logic              wb_valid,
    input  logic [DATA_W-1:0] WB_Data,
    output logic [CNT_W-1:0]  pass_count,
    output logic [CNT_W-1:0]  fail_count,
    output logic [CNT_W-1:0]  skip_count,
    output logic [CNT_W-1:0]  cycle,
    output logic              mismatch,
    output logic [CNT_W-1:0]  first_fail_cycle,
    output logic [DATA_W-1:0] first_fail_exp,
    output logic [DATA_W-1:0] first_fail_got,
    output logic              underflow,
    output logic              done
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned OccW = $clog2(DEPTH + 1);
    localparam logic [OccW-1:0] OccFull = OccW'(DEPTH);

    logic [DATA_W:0]     mem_q [DEPTH];
    logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [OccW-1:0]     occ_q, occ_d;
    logic [CNT_W-1:0]    pass_q, pass_d, fail_q, fail_d, skip_q, skip_d, cycle_q;
    logic [CNT_W-1:0]    ff_cycle_q;
    logic [DATA_W-1:0]   ff_exp_q, ff_got_q;
    logic                ff_set_q, mismatch_q, underflow_q, popped_q;

    logic                push, pop, head_skip, do_skip, do_pass, do_fail;
    logic [DATA_W-1:0]   head_data;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    assign exp_ready = occ_q < OccFull;
    assign push      = exp_valid && exp_ready;
    // Pop decision uses the registered occupancy, so a push in the same cycle
    // never bypasses into an empty queue.
    assign pop       = wb_valid && (occ_q != '0);
    assign head_skip = mem_q[rd_ptr_q][DATA_W];
    assign head_data = mem_q[rd_ptr_q][DATA_W-1:0];
    assign do_skip   = pop && head_skip;
    assign do_pass   = pop && !head_skip && (head_data == WB_Data);
    assign do_fail   = pop && !head_skip && (head_data != WB_Data);

    always_comb begin
        occ_d  = occ_q;
        pass_d = do_pass ? sat_inc(pass_q) : pass_q;
        fail_d = do_fail ? sat_inc(fail_q) : fail_q;
        skip_d = do_skip ? sat_inc(skip_q) : skip_q;
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    // Queue storage carries no reset; pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q] <= {exp_skip, exp_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            pass_q      <= '0;
            fail_q      <= '0;
            skip_q      <= '0;
            cycle_q     <= '0;
            ff_set_q    <= 1'b0;
            ff_cycle_q  <= '0;
            ff_exp_q    <= '0;
            ff_got_q    <= '0;
            mismatch_q  <= 1'b0;
            underflow_q <= 1'b0;
            popped_q    <= 1'b0;
        end else begin
            // DEPTH is a power of two, so pointers wrap by natural overflow.
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            occ_q      <= occ_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            skip_q     <= skip_d;
            cycle_q    <= sat_inc(cycle_q);
            mismatch_q <= do_fail;
            if (pop) popped_q <= 1'b1;
            if (wb_valid && (occ_q == '0)) underflow_q <= 1'b1;
            if (do_fail && !ff_set_q) begin
                ff_set_q   <= 1'b1;
                ff_cycle_q <= cycle_q;
                ff_exp_q   <= head_data;
                ff_got_q   <= WB_Data;
            end
        end
    end

    assign pass_count       = pass_q;
    assign fail_count       = fail_q;
    assign skip_count       = skip_q;
    assign cycle            = cycle_q;
    assign mismatch         = mismatch_q;
    assign first_fail_cycle = ff_cycle_q;
    assign first_fail_exp   = ff_exp_q;
    assign first_fail_got   = ff_got_q;
    assign underflow        = underflow_q;
    assign done             = (occ_q == '0) && popped_q;

endmodule

// File: tb/tb_wb_checker.sv
// Bench for wb_checker: a queue-based reference model tracks expected entries
// and result counters; every step compares all DUT outputs against it.
module tb_wb_checker;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int CW    = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          exp_valid, exp_ready, exp_skip, wb_valid;
    logic [DW-1:0] exp_data, WB_Data;
    logic [CW-1:0] pass_count, fail_count, skip_count, cycle, first_fail_cycle;
    logic [DW-1:0] first_fail_exp, first_fail_got;
    logic          mismatch, underflow, done;

    wb_checker #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)) u_dut (
        .clk(clk), .reset(reset),
        .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_data(exp_data),
        .exp_skip(exp_skip), .wb_valid(wb_valid), .WB_Data(WB_Data),
        .pass_count(pass_count), .fail_count(fail_count), .skip_count(skip_count),
        .cycle(cycle), .mismatch(mismatch), .first_fail_cycle(first_fail_cycle),
        .first_fail_exp(first_fail_exp), .first_fail_got(first_fail_got),
        .underflow(underflow), .done(done)
    );

    // Narrow-counter instance for saturation.
    logic          s_exp_valid, s_exp_ready, s_exp_skip, s_wb_valid;
    logic [DW-1:0] s_exp_data, s_wb_data, s_ff_exp, s_ff_got;
    logic [3:0]    s_pass, s_fail, s_skip, s_cycle, s_ff_cycle;
    logic          s_mismatch, s_underflow, s_done;

    wb_checker #(.DATA_W(DW), .DEPTH(4), .CNT_W(4)) u_dut_sat (
        .clk(clk), .reset(reset),
        .exp_valid(s_exp_valid), .exp_ready(s_exp_ready), .exp_data(s_exp_data),
        .exp_skip(s_exp_skip), .wb_valid(s_wb_valid), .WB_Data(s_wb_data),
        .pass_count(s_pass), .fail_count(s_fail), .skip_count(s_skip),
        .cycle(s_cycle), .mismatch(s_mismatch), .first_fail_cycle(s_ff_cycle),
        .first_fail_exp(s_ff_exp), .first_fail_got(s_ff_got),
        .underflow(s_underflow), .done(s_done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference model
    logic [DW:0]   mdl_q [$];
    int unsigned   m_pass, m_fail, m_skip, m_cycle, m_ff_cycle;
    bit            m_uf, m_popped, m_mm, m_ff_set;
    logic [DW-1:0] m_ff_exp, m_ff_got;

    task automatic model_clear();
        mdl_q.delete();
        m_pass = 0; m_fail = 0; m_skip = 0; m_cycle = 0; m_ff_cycle = 0;
        m_uf = 0; m_popped = 0; m_mm = 0; m_ff_set = 0;
        m_ff_exp = '0; m_ff_got = '0;
    endtask

    task automatic check_all();
        check_val("pass_count", 64'(pass_count), 64'(m_pass));
        check_val("fail_count", 64'(fail_count), 64'(m_fail));
        check_val("skip_count", 64'(skip_count), 64'(m_skip));
        check_val("cycle", 64'(cycle), 64'(m_cycle));
        check_val("mismatch", 64'(mismatch), 64'(m_mm));
        check_val("underflow", 64'(underflow), 64'(m_uf));
        check_val("done", 64'(done), 64'(m_popped && mdl_q.size() == 0));
        check_val("exp_ready", 64'(exp_ready), 64'(mdl_q.size() < DEPTH));
        check_val("ff_cycle", 64'(first_fail_cycle), 64'(m_ff_cycle));
        check_val("ff_exp", 64'(first_fail_exp), 64'(m_ff_exp));
        check_val("ff_got", 64'(first_fail_got), 64'(m_ff_got));
    endtask

    // One clock: optional push and optional sample, then compare after the edge.
    task automatic step(input bit pv, input bit pskip, input logic [DW-1:0] pdata,
                        input bit sv, input logic [DW-1:0] sdata);
        bit          acc;
        logic [DW:0] e;
        exp_valid = pv; exp_skip = pskip; exp_data = pdata;
        wb_valid  = sv; WB_Data  = sdata;
        acc  = pv && (mdl_q.size() < DEPTH);
        m_mm = 0;
        if (sv) begin
            if (mdl_q.size() > 0) begin
                e = mdl_q.pop_front();
                m_popped = 1;
                if (e[DW]) m_skip++;
                else if (e[DW-1:0] == sdata) m_pass++;
                else begin
                    m_fail++;
                    m_mm = 1;
                    if (!m_ff_set) begin
                        m_ff_set = 1; m_ff_cycle = m_cycle;
                        m_ff_exp = e[DW-1:0]; m_ff_got = sdata;
                    end
                end
            end else begin
                m_uf = 1;
            end
        end
        if (acc) mdl_q.push_back({pskip, pdata});
        @(posedge clk); #1;
        m_cycle++;
        exp_valid = 0; wb_valid = 0;
        check_all();
    endtask

    // Valids are held high through the reset edge; they must be ignored.
    task automatic do_reset();
        reset = 1; exp_valid = 1; exp_skip = 0; exp_data = 32'h55; wb_valid = 1;
        @(posedge clk); #1;
        reset = 0; exp_valid = 0; wb_valid = 0;
        model_clear();
        check_all();
    endtask

    initial begin
        reset = 0; exp_valid = 0; exp_skip = 0; exp_data = '0;
        wb_valid = 0; WB_Data = '0;
        s_exp_valid = 0; s_exp_skip = 0; s_exp_data = '0;
        s_wb_valid = 0; s_wb_data = '0;
        model_clear();

        // Skips followed by two passing compares
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 1, 32'h0, 0, '0);
        step(1, 0, 32'h1, 0, '0);
        step(1, 0, 32'h14, 0, '0);
        for (int i = 0; i < 5; i++) step(0, 0, '0, 1, 32'hdead);
        step(0, 0, '0, 1, 32'h1);
        step(0, 0, '0, 1, 32'h14);
        check_val("seq_skip5", 64'(skip_count), 64'd5);
        check_val("seq_pass2", 64'(pass_count), 64'd2);
        check_val("seq_done", 64'(done), 64'd1);

        // Single failure at cycle 6 and first-fail record
        do_reset();
        step(1, 0, 32'h14, 0, '0);
        while (m_cycle < 6) step(0, 0, '0, 0, '0);
        step(0, 0, '0, 1, 32'h15);
        check_val("fail_mm", 64'(mismatch), 64'd1);
        check_val("fail_cyc6", 64'(first_fail_cycle), 64'd6);
        check_val("fail_exp", 64'(first_fail_exp), 64'h14);
        check_val("fail_got", 64'(first_fail_got), 64'h15);
        step(0, 0, '0, 0, '0);
        check_val("fail_mm_low", 64'(mismatch), 64'd0);

        // Fill to DEPTH, 17th offer refused, drain in order
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1, 0, 32'h100 + i, 0, '0);
        check_val("full_ready0", 64'(exp_ready), 64'd0);
        step(1, 0, 32'hbad, 0, '0);
        for (int i = 0; i < DEPTH; i++) step(0, 0, '0, 1, 32'h100 + i);
        check_val("full_pass16", 64'(pass_count), 64'd16);
        check_val("full_done", 64'(done), 64'd1);

        // Underflow with simultaneous push; pushed entry survives
        do_reset();
        step(1, 0, 32'hA, 1, 32'hA);
        check_val("uf_flag", 64'(underflow), 64'd1);
        check_val("uf_pass0", 64'(pass_count), 64'd0);
        step(0, 0, '0, 1, 32'hA);
        check_val("uf_pass1", 64'(pass_count), 64'd1);

        // Reset mid-operation: 3 queued, 2 failures
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 0, 32'h30 + i, 0, '0);
        step(0, 0, '0, 1, 32'hffff);
        step(0, 0, '0, 1, 32'hffff);
        check_val("mid_fail2", 64'(fail_count), 64'd2);
        do_reset();
        check_val("mid_fail0", 64'(fail_count), 64'd0);
        check_val("mid_ff0", 64'(first_fail_exp), 64'd0);
        step(0, 0, '0, 1, 32'h30);
        check_val("mid_empty", 64'(underflow), 64'd1);

        // Random push/sample mix: wrap-around, concurrent push/pop, failures
        do_reset();
        for (int i = 0; i < 300; i++) begin
            step(bit'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
                 32'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                 32'($urandom_range(0, 3)));
        end

        // Saturation at CNT_W=4: 20 passes hold at 15
        do_reset();
        s_exp_valid = 1; s_exp_data = 32'h5;
        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) begin
            s_wb_valid = 1; s_wb_data = 32'h5;
            @(posedge clk); #1;
            if (i == 14) check_val("sat_at15", 64'(s_pass), 64'd15);
        end
        s_exp_valid = 0; s_wb_valid = 0;
        check_val("sat_hold15", 64'(s_pass), 64'd15);
        check_val("sat_fail0", 64'(s_fail), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
